writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 114 +++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
// Register-file writeback queue: merges ALU and load-unit writebacks into an
// in-order FIFO drained through a single register-file write port, with forwarding lookup.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [1:0]                 alu_reg,
    input  logic [7:0]                 alu_value,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [1:0]                 mem_reg,
    input  logic [7:0]                 mem_value,
    output logic                       mem_ready,
    input  logic                       drain_en,
    output logic                       write_en,
    output logic [1:0]                 write_reg,
    output logic [7:0]                 write_value,
    input  logic [1:0]                 r_a,
    input  logic [1:0]                 r_b,
    output logic                       fwd_a_hit,
    output logic [7:0]                 fwd_a_value,
    output logic                       fwd_b_hit,
    output logic [7:0]                 fwd_b_value,
    output logic [3:0]                 pending,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_FREE = CW'(DEPTH - 1);

    logic [1:0]    reg_q [DEPTH];
    logic [7:0]    val_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;

    logic          mem_push;
    logic          alu_push;
    logic          pop;
    logic [1:0]    push_cnt;
    logic [PW-1:0] alu_slot;
    logic [PW-1:0] scan_idx;

    // Handshake: a request transfers on the rising edge where valid && ready.
    // Ready looks only at the registered count, so a same-cycle drain never
    // makes room; the load unit has priority for the last free slot.
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign mem_ready = (count_q <= LAST_FREE);
    assign alu_ready = (count_q < LAST_FREE) || ((count_q == LAST_FREE) && !mem_valid);

    assign mem_push  = mem_valid && mem_ready;
    assign alu_push  = alu_valid && alu_ready;
    assign pop       = drain_en && !empty;
    assign push_cnt  = {1'b0, mem_push} + {1'b0, alu_push};
    // The load entry is older, so the ALU entry lands one slot behind it.
    assign alu_slot  = tail + PW'(mem_push);

    assign write_en    = pop;
    assign write_reg   = pop ? reg_q[head] : 2'd0;
    assign write_value = pop ? val_q[head] : 8'd0;

    // Scan oldest to youngest so the last match is the youngest write.
    always_comb begin
        fwd_a_hit   = 1'b0;
        fwd_a_value = 8'd0;
        fwd_b_hit   = 1'b0;
        fwd_b_value = 8'd0;
        pending     = 4'd0;
        scan_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PW'(k);
            if (CW'(k) < count_q) begin
                pending[reg_q[scan_idx]] = 1'b1;
                if (reg_q[scan_idx] == r_a) begin
                    fwd_a_hit   = 1'b1;
                    fwd_a_value = val_q[scan_idx];
                end
                if (reg_q[scan_idx] == r_b) begin
                    fwd_b_hit   = 1'b1;
                    fwd_b_value = val_q[scan_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (mem_push) begin
                reg_q[tail] <= mem_reg;
                val_q[tail] <= mem_value;
            end
            if (alu_push) begin
                reg_q[alu_slot] <= alu_reg;
                val_q[alu_slot] <= alu_value;
            end
            tail    <= tail + PW'(push_cnt);
            head    <= head + PW'(pop);
            count_q <= count_q + CW'(push_cnt) - CW'(pop);
        end
    end

endmodule
